// File: rtl/switch_mcu_inst_encoder_if.sv
// -----------------------------------------------------------------------------
// switch_mcu_inst_encoder_if
//
// Request and issue bus between an instruction requester (debug injector or
// self-test sequencer) and switch_mcu_inst_encoder.
//
//   Request side (driven by master):
//     in_valid        request valid
//     in_format       0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//     in_opcode       inst[6:0]
//     in_funct3       inst[14:12]
//     in_funct7       inst[31:25] (R only)
//     in_rd           inst[11:7]
//     in_rs1          inst[19:15]
//     in_rs2          inst[24:20]
//     in_imm          byte offset / immediate, two's complement
//   Response side (driven by slave):
//     out_ready       encoder accepts a request this cycle
//     out_inst        encoded word, stable for the whole slot
//     out_cycle_cnt   slot cycle counter, consumer latches on 0, 4'hF when idle
//     out_inst_valid  high during an issue slot
//     out_err         one-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
interface switch_mcu_inst_encoder_if;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  in_format;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic [31:0] out_inst;
    logic [3:0]  out_cycle_cnt;
    logic        out_inst_valid;
    logic        out_err;

    // Requester side
    modport master (
        output in_valid, in_format, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready, out_inst, out_cycle_cnt, out_inst_valid, out_err
    );

    // Encoder side
    modport slave (
        input  in_valid, in_format, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm,
        output out_ready, out_inst, out_cycle_cnt, out_inst_valid, out_err
    );
endinterface

// File: rtl/switch_mcu_inst_encoder.sv
// -----------------------------------------------------------------------------
// switch_mcu_inst_encoder
//
// Packs decoded instruction fields into an RV32I instruction word and issues
// it to the switch MCU decoder for one slot of CYCLES_PER_INST cycles. The
// decoder latches out_inst when out_cycle_cnt is 0; outside a slot the counter
// parks at 4'hF so the decoder never re-latches a stale word.
//
// Requests whose immediate does not fit the selected format (range or
// alignment) or whose format code is 6/7 are rejected: out_err pulses for one
// cycle and the issued word and counter are left untouched.
//
// Parameters:
//   CYCLES_PER_INST  cycles per issue slot, legal range 2..15
// Ports:
//   in_clk   clock, rising edge
//   in_rst   synchronous reset, active low
//   bus      switch_mcu_inst_encoder_if.slave (request + issue signals)
// -----------------------------------------------------------------------------
module switch_mcu_inst_encoder #(
    parameter int CYCLES_PER_INST = 4
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    switch_mcu_inst_encoder_if.slave    bus
);

    localparam logic [3:0]  LAST_CNT = 4'(CYCLES_PER_INST - 1);
    localparam logic [3:0]  IDLE_CNT = 4'hF;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] inst_reg,  inst_next;
    logic [3:0]  cnt_reg,   cnt_next;
    logic        err_reg,   err_next;

    logic [31:0] enc_word;
    logic        imm_ok;
    logic        ready;
    logic        xfer;
    logic        last_cnt;

    // -------------------------------------------------------------------------
    // Immediate range checks. sign_agree[b] is set when bit b equals the sign
    // bit, so "imm[31:k] all equal" reduces to an AND over sign_agree[31:k].
    // -------------------------------------------------------------------------
    logic [31:0] sign_agree;

    for (genvar gi = 0; gi < 32; gi++) begin : g_sign_agree
        assign sign_agree[gi] = ~(bus.in_imm[gi] ^ bus.in_imm[31]);
    end

    logic fits_s12;   // I/S: signed 12-bit
    logic fits_s13;   // B:   signed 13-bit byte offset
    logic fits_s21;   // J:   signed 21-bit byte offset
    logic imm_even;   // B/J: halfword aligned
    logic low12_zero; // U:   lower 12 bits are implied zero

    assign fits_s12   = &sign_agree[31:11];
    assign fits_s13   = &sign_agree[31:12];
    assign fits_s21   = &sign_agree[31:20];
    assign imm_even   = ~bus.in_imm[0];
    assign low12_zero = ~|bus.in_imm[11:0];

    // -------------------------------------------------------------------------
    // Format packing, including the B/J immediate bit scrambling.
    // -------------------------------------------------------------------------
    always_comb begin
        enc_word = NOP_INST;
        imm_ok   = 1'b0;
        unique case (bus.in_format)
            FMT_R: begin
                enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_rd, bus.in_opcode};
                imm_ok   = 1'b1;
            end
            FMT_I: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
                imm_ok   = fits_s12;
            end
            FMT_S: begin
                enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_imm[4:0], bus.in_opcode};
                imm_ok   = fits_s12;
            end
            FMT_B: begin
                enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                            bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                            bus.in_imm[11], bus.in_opcode};
                imm_ok   = imm_even & fits_s13;
            end
            FMT_U: begin
                enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
                imm_ok   = low12_zero;
            end
            FMT_J: begin
                enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                            bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
                imm_ok   = imm_even & fits_s21;
            end
            default: begin
                // Format codes 6 and 7 have no encoding.
                enc_word = NOP_INST;
                imm_ok   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake. The encoder can take the next request on the final cycle of a
    // slot so that back-to-back requests issue with no idle gap.
    // -------------------------------------------------------------------------
    assign last_cnt = (cnt_reg == LAST_CNT);
    assign ready    = (state_reg == ST_IDLE) | last_cnt;
    assign xfer     = bus.in_valid & ready;

    // -------------------------------------------------------------------------
    // Slot FSM: next-state and register updates.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        inst_next  = inst_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    if (imm_ok) begin
                        state_next = ST_ISSUE;
                        inst_next  = enc_word;
                        cnt_next   = 4'd0;
                    end else begin
                        err_next   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (!last_cnt) begin
                    cnt_next = cnt_reg + 4'd1;
                end else if (xfer && imm_ok) begin
                    // Back-to-back: the new slot starts straight away.
                    state_next = ST_ISSUE;
                    inst_next  = enc_word;
                    cnt_next   = 4'd0;
                end else begin
                    // Slot ends; a rejected request here still drops to idle.
                    state_next = ST_IDLE;
                    cnt_next   = IDLE_CNT;
                    err_next   = xfer;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = IDLE_CNT;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_reg <= ST_IDLE;
            inst_reg  <= NOP_INST;
            cnt_reg   <= IDLE_CNT;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            inst_reg  <= inst_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.out_ready      = ready;
    assign bus.out_inst       = inst_reg;
    assign bus.out_cycle_cnt  = cnt_reg;
    assign bus.out_inst_valid = (state_reg == ST_ISSUE);
    assign bus.out_err        = err_reg;

endmodule

// File: tb/tb_switch_mcu_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_switch_mcu_inst_encoder
//
// Driver issues requests on the falling edge and pushes the expected response
// (encoded word or reject pulse, plus the cycle it is due) into a queue. A
// monitor on the falling edge pops and compares whenever the encoder shows a
// slot start or an error pulse, and also checks counter stepping, slot length,
// word hold and out_ready every cycle.
// -----------------------------------------------------------------------------
module tb_switch_mcu_inst_encoder;

    localparam int CPI = 4;

    logic in_clk = 1'b0;
    logic in_rst = 1'b0;

    always #5 in_clk = ~in_clk;

    switch_mcu_inst_encoder_if bus ();

    switch_mcu_inst_encoder #(
        .CYCLES_PER_INST (CPI)
    ) dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] word;
        int          due;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge in_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_legal(input int fmt, input logic [31:0] imm);
        int s;
        s = int'(imm);
        case (fmt)
            0:       return 1'b1;
            1, 2:    return (s >= -2048) && (s <= 2047);
            3:       return (s % 2 == 0) && (s >= -4096) && (s <= 4095);
            4:       return (imm % 4096) == 0;
            5:       return (s % 2 == 0) && (s >= -1048576) && (s <= 1048575);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input int fmt, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [31:0] imm);
        case (fmt)
            0: return {f7, rs2, rs1, f3, rd, op};
            1: return {imm[11:0], rs1, f3, rd, op};
            2: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            3: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            4: return {imm[31:12], rd, op};
            5: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- monitor ----------------
    bit          mon_en = 1'b0;
    logic        prev_valid;
    logic [3:0]  prev_cnt;
    logic [31:0] last_word;
    logic [3:0]  want_cnt;
    exp_t        mon_e;

    always @(negedge in_clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_event: got none expected %s due cycle %0d",
                         sb[0].is_err ? "err" : "slot", sb[0].due);
                void'(sb.pop_front());
            end

            if (bus.out_err || (bus.out_inst_valid && bus.out_cycle_cnt == 4'd0)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {31'd0, bus.out_err}, {31'd0, ~bus.out_err});
                end else begin
                    mon_e = sb.pop_front();
                    $display("event cycle %0d: %s inst=%h", cyc,
                             bus.out_err ? "reject" : "issue", bus.out_inst);
                    chk("event_cycle", 32'(cyc), 32'(mon_e.due));
                    chk("event_kind", {31'd0, bus.out_err}, {31'd0, mon_e.is_err});
                    if (mon_e.is_err) begin
                        chk("err_no_valid", {31'd0, bus.out_inst_valid}, 32'd0);
                        chk("err_inst_hold", bus.out_inst, last_word);
                    end else begin
                        chk("inst_word", bus.out_inst, mon_e.word);
                        last_word = mon_e.word;
                    end
                end
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_event: got none expected %s at cycle %0d",
                         sb[0].is_err ? "err" : "slot", cyc);
                void'(sb.pop_front());
            end

            chk("ready", {31'd0, bus.out_ready},
                {31'd0, (!bus.out_inst_valid) || (bus.out_cycle_cnt == 4'(CPI - 1))});
            if (bus.out_inst_valid) begin
                want_cnt = (prev_valid && prev_cnt != 4'(CPI - 1)) ? prev_cnt + 4'd1 : 4'd0;
                chk("cnt_step", {28'd0, bus.out_cycle_cnt}, {28'd0, want_cnt});
                if (bus.out_cycle_cnt != 4'd0) chk("slot_inst_hold", bus.out_inst, last_word);
            end else begin
                chk("idle_cnt", {28'd0, bus.out_cycle_cnt}, 32'hF);
                chk("idle_inst_hold", bus.out_inst, last_word);
                if (prev_valid) chk("slot_len", {28'd0, prev_cnt}, 32'(CPI - 1));
            end
            prev_valid = bus.out_inst_valid;
            prev_cnt   = bus.out_cycle_cnt;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_format = 3'(fmt);
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        for (int n = 0; n < 64; n++) begin
            if (bus.out_ready) begin
                e.is_err = !model_legal(fmt, imm);
                e.word   = model_word(fmt, op, f3, f7, rd, rs1, rs2, imm);
                e.due    = cyc + 1;
                sb.push_back(e);
                @(negedge in_clk);
                return;
            end
            @(negedge in_clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL handshake_timeout: got out_ready=0 for 64 cycles expected 1");
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge in_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] imm;
        int          fmt;
        int          t;

        bus.in_valid  = 1'b0;
        bus.in_format = 3'd0;
        bus.in_opcode = 7'd0;
        bus.in_funct3 = 3'd0;
        bus.in_funct7 = 7'd0;
        bus.in_rd     = 5'd0;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_imm    = 32'd0;

        // Reset values
        in_rst = 1'b0;
        repeat (3) @(negedge in_clk);
        chk("rst_inst", bus.out_inst, 32'h0000_0013);
        chk("rst_cnt", {28'd0, bus.out_cycle_cnt}, 32'hF);
        chk("rst_valid", {31'd0, bus.out_inst_valid}, 32'd0);
        chk("rst_err", {31'd0, bus.out_err}, 32'd0);
        chk("rst_ready", {31'd0, bus.out_ready}, 32'd1);
        in_rst     = 1'b1;
        prev_valid = 1'b0;
        prev_cnt   = 4'hF;
        last_word  = 32'h0000_0013;
        mon_en     = 1'b1;

        // Directed encodings
        send(1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        idle(6);
        chk("dir_I", last_word, 32'hFFF1_0093);
        send(2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd8);
        idle(6);
        chk("dir_S", last_word, 32'h0051_2423);
        send(4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        idle(6);
        chk("dir_U", last_word, 32'h1234_52B7);
        send(3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        idle(6);
        chk("dir_B", last_word, 32'hFE20_8EE3);
        send(5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        idle(6);
        chk("dir_J", last_word, 32'h0010_00EF);

        // Rejects
        send(3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        idle(3);
        send(4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
        idle(3);
        send(1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0800);
        idle(3);
        send(7, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        idle(3);
        chk("rej_word_kept", last_word, 32'h0010_00EF);

        // Back-to-back, then a reject at the last count
        send(0, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0);
        send(0, 7'b0110011, 3'd7, 7'h00, 5'd6, 5'd7, 5'd8, 32'd0);
        send(1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h0000_1000);
        idle(6);

        // Reset mid-slot at count 2
        send(1, 7'b0010011, 3'd0, 7'd0, 5'd9, 5'd10, 5'd0, 32'd5);
        idle(0);
        t = 0;
        while (bus.out_cycle_cnt != 4'd2 && t < 16) begin
            @(negedge in_clk);
            t++;
        end
        chk("reach_cnt2", {28'd0, bus.out_cycle_cnt}, 32'd2);
        mon_en = 1'b0;
        in_rst = 1'b0;
        @(negedge in_clk);
        chk("midrst_inst", bus.out_inst, 32'h0000_0013);
        chk("midrst_cnt", {28'd0, bus.out_cycle_cnt}, 32'hF);
        chk("midrst_valid", {31'd0, bus.out_inst_valid}, 32'd0);
        chk("midrst_ready", {31'd0, bus.out_ready}, 32'd1);
        in_rst     = 1'b1;
        prev_valid = 1'b0;
        prev_cnt   = 4'hF;
        last_word  = 32'h0000_0013;
        mon_en     = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 250; k++) begin
            fmt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7))
                                               : int'($urandom_range(0, 5));
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                2: imm = $urandom & 32'hFFFF_F000;
                3: imm = 32'(int'($urandom_range(0, 32'h1F_FFFF)) - 1048576);
                default: imm = 32'(int'($urandom_range(0, 4)) * 2 - 4);
            endcase
            send(fmt, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), imm);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 5)));
        end
        idle(8);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/switch_mcu_inst_encoder.md
# switch_mcu_inst_encoder

Instruction encoder and issuer that feeds the switch MCU decoder. It accepts decoded instruction fields over a valid/ready handshake and packs them into a standard RV32I 32-bit instruction word, including per-format immediate scrambling and range checks. It then presents the word together with a slot cycle counter, so the downstream decoder latches the word when the counter is 0. Used for debug instruction injection and self-test stimulus.

## Interface
- CYCLES_PER_INST, 4, cycles per issue slot; legal range 2..15.

- in_clk  input  1  clock, rising edge.
- in_rst  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- out_ready  output  1  encoder can accept a request this cycle.
- in_format  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  input  7  placed in inst[6:0].
- in_funct3  input  3  placed in inst[14:12] (R/I/S/B).
- in_funct7  input  7  placed in inst[31:25] (R only).
- in_rd  input  5  placed in inst[11:7] (R/I/U/J).
- in_rs1  input  5  placed in inst[19:15] (R/I/S/B).
- in_rs2  input  5  placed in inst[24:20] (R/S/B).
- in_imm  input  32  byte-offset/immediate value, two's complement.
- out_inst  output  32  encoded instruction, held for the whole slot.
- out_cycle_cnt  output  4  slot cycle counter; the consumer latches out_inst on 0.
- out_inst_valid  output  1  high during an issue slot.
- out_err  output  1  one-cycle pulse on a rejected request.

## Operation
- Handshake: a request transfers on in_valid & out_ready. All inputs are sampled only on that cycle.
- Encoding by format:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Legality checks (any failure means reject):
  - I/S: imm[31:11] all equal (fits signed 12-bit).
  - B: imm[0]==0 and imm[31:12] all equal.
  - J: imm[0]==0 and imm[31:20] all equal.
  - U: imm[11:0]==0.
  - Format 6 or 7 is rejected.
  - R ignores in_imm.
- Reject behaviour: out_err=1 for exactly the cycle after the transfer. No slot starts, and out_inst / out_cycle_cnt are unchanged.
- States:
  - IDLE: out_ready=1, out_inst_valid=0.
  - ISSUE: counter runs 0..CYCLES_PER_INST-1.
- Transitions:
  - IDLE + legal transfer -> ISSUE, counter 0.
  - ISSUE at the last count with no legal transfer -> IDLE.
  - ISSUE at the last count with a legal transfer -> ISSUE, counter 0 (back-to-back).
  - A rejected transfer at the last count -> IDLE, with the out_err pulse.
- out_ready = (state==IDLE) | (out_cycle_cnt==CYCLES_PER_INST-1).
- In IDLE, out_inst holds the last word and out_cycle_cnt holds 4'hF, so the consumer never re-latches.

## Timing
- Reset values, applied on the next edge after in_rst is sampled low:
  - state IDLE.
  - out_inst = 32'h00000013 (NOP).
  - out_cycle_cnt = 4'hF.
  - out_inst_valid = 0, out_err = 0, out_ready = 1.
- Latency: transfer at edge N. At edge N+1: out_inst is the new word, out_cycle_cnt=0, out_inst_valid=1.
- The counter increments by 1 per cycle. The slot lasts exactly CYCLES_PER_INST cycles.
- Sustained throughput is one instruction per CYCLES_PER_INST cycles, with no idle gap.
- Reset mid-slot aborts the slot. No partial word is retained.
- in_valid while out_ready=0 is ignored. The requester must hold its request until a transfer occurs.

## Test plan
- I, opcode 0010011, f3 0, rd 1, rs1 2, imm 0xFFFFFFFF -> out_inst 0xFFF10093 one cycle after transfer; cnt 0,1,2,3; then IDLE with cnt F.
- S, opcode 0100011, f3 2, rs1 2, rs2 5, imm 8 -> 0x00512423. Then U, opcode 0110111, rd 5, imm 0x12345000 -> 0x123452B7.
- B, opcode 1100011, f3 0, rs1 1, rs2 2, imm 0xFFFFFFFC -> 0xFE208EE3. Then J, opcode 1101111, rd 1, imm 0x800 -> 0x001000EF.
- Rejects: B imm 3, U imm 0x12345001, I imm 0x800, format 7 -> out_err one-cycle pulse each; out_inst_valid stays 0; out_inst unchanged.
- Back-to-back: in_valid held high for two requests, CYCLES_PER_INST=4 -> cnt 0,1,2,3,0,1,2,3 then F; out_ready high only at cnt 3 and in IDLE.
- Reset: in_rst low at cnt 2 -> next cycle out_inst 0x00000013, cnt F, out_inst_valid 0, out_ready 1.
